// File: rtl/parser_sched_pkg.sv
// Shared types and constants for the Snappy token scheduler.
// Token length limits and the scheduler state encoding live here.
package parser_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERR
    } sched_state_t;

    localparam int MAX_TOK_LEN = 64;
    localparam int TOK_LEN_W   = 7;

    function automatic logic len_ok(input logic [TOK_LEN_W-1:0] len);
        return (len != '0) && (len <= TOK_LEN_W'(MAX_TOK_LEN));
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sched_lane_rr.sv
// Strict round-robin lane pointer with one-hot decode.
// Advances only on a completed dispatch; never skips a lane.
module sched_lane_rr #(
    parameter int NUM_LANES = 4,
    localparam int PTR_W = $clog2(NUM_LANES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 advance,
    output logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] onehot
);

    // pointer register: clear wins over advance, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

    // one-hot decode of the current pointer
    always_comb begin
        onehot      = '0;
        onehot[ptr] = 1'b1;
    end

endmodule

// File: rtl/parser_token_scheduler.sv
// Dispatches parser tokens round-robin into execution lanes with seq tags.
// Optional statistics counters: define PARSER_SCHED_STAT_EN.
module parser_token_scheduler
    import parser_sched_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TOK_W     = 64,
    parameter int SEQ_W     = 8,
    parameter int ULEN_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ULEN_W-1:0]    ulen,
    input  logic                 tok_valid,
    output logic                 tok_ready,
    input  logic                 tok_is_copy,
    input  logic [6:0]           tok_len,
    input  logic [TOK_W-1:0]     tok_data,
    output logic [NUM_LANES-1:0] lane_valid,
    input  logic [NUM_LANES-1:0] lane_ready,
    output logic                 lane_is_copy,
    output logic [6:0]           lane_len,
    output logic [TOK_W-1:0]     lane_data,
    output logic [SEQ_W-1:0]     lane_seq,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef PARSER_SCHED_STAT_EN
    ,
    output logic [31:0]          stat_lit_cnt,
    output logic [31:0]          stat_copy_cnt,
    output logic [31:0]          stat_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_LANES);

    sched_state_t state, state_nx;

    logic [ULEN_W-1:0]    ulen_q;
    logic [ULEN_W:0]      cnt_q;
    logic [ULEN_W:0]      sum;
    logic [SEQ_W-1:0]     seq_q;

    logic                 hold_valid;
    logic                 hold_copy;
    logic [6:0]           hold_len;
    logic [TOK_W-1:0]     hold_data;
    logic [SEQ_W-1:0]     hold_seq;

    logic [PTR_W-1:0]     ptr;
    logic [NUM_LANES-1:0] ptr_oh;

    logic start_go;
    logic dispatch;
    logic accept;
    logic tok_bad;
    logic load;
    logic fault;
    logic last;

    assign start_go = start && (state == IDLE || state == DONE || state == ERR);
    assign dispatch = hold_valid && lane_ready[ptr];
    assign accept   = tok_valid && tok_ready;
    assign sum      = cnt_q + (ULEN_W+1)'(tok_len);
    assign tok_bad  = !len_ok(tok_len) || (sum > {1'b0, ulen_q});
    assign load     = accept && !tok_bad;
    assign fault    = accept && tok_bad;
    assign last     = (sum == {1'b0, ulen_q});

    sched_lane_rr #(
        .NUM_LANES (NUM_LANES)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (start_go),
        .advance (dispatch),
        .ptr     (ptr),
        .onehot  (ptr_oh)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state: an empty block finishes straight away
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx = (ulen == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fault) begin
                    state_nx = ERR;
                end else if (load && last) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!hold_valid || dispatch) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state; ready also when hold drains this cycle
    always_comb begin
        tok_ready = (state == RUN) && (!hold_valid || lane_ready[ptr]);
        busy      = (state == RUN) || (state == DRAIN);
        done      = (state == DONE);
        err       = (state == ERR);
    end

    // block bookkeeping: length limit, running byte count, seq tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ulen_q <= '0;
            cnt_q  <= '0;
            seq_q  <= '0;
        end else if (start_go) begin
            ulen_q <= ulen;
            cnt_q  <= '0;
            seq_q  <= '0;
        end else if (load) begin
            cnt_q  <= sum;
            seq_q  <= seq_q + SEQ_W'(1);
        end
    end

    // one-entry hold: reload on accept, empty on dispatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_copy  <= 1'b0;
            hold_len   <= '0;
            hold_data  <= '0;
            hold_seq   <= '0;
        end else if (load) begin
            hold_valid <= 1'b1;
            hold_copy  <= tok_is_copy;
            hold_len   <= tok_len;
            hold_data  <= tok_data;
            hold_seq   <= seq_q;
        end else if (dispatch) begin
            hold_valid <= 1'b0;
        end
    end

    assign lane_valid   = hold_valid ? ptr_oh : '0;
    assign lane_is_copy = hold_copy;
    assign lane_len     = hold_len;
    assign lane_data    = hold_data;
    assign lane_seq     = hold_seq;

`ifdef PARSER_SCHED_STAT_EN
    // saturating token-mix and stall statistics, cleared per block
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lit_cnt   <= '0;
            stat_copy_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else if (start_go) begin
            stat_lit_cnt   <= '0;
            stat_copy_cnt  <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (accept && !tok_is_copy) begin
                stat_lit_cnt <= sat_inc32(stat_lit_cnt);
            end
            if (accept && tok_is_copy) begin
                stat_copy_cnt <= sat_inc32(stat_copy_cnt);
            end
            if (hold_valid && !lane_ready[ptr]) begin
                stat_stall_cnt <= sat_inc32(stat_stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_parser_token_scheduler.sv
// Directed bench for parser_token_scheduler with a dispatch scoreboard.
// Build with PARSER_SCHED_STAT_EN to also cover the statistics outputs.
module tb_parser_token_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ulen = '0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_is_copy = 1'b0;
    logic [6:0]  tok_len = '0;
    logic [63:0] tok_data = '0;
    logic [3:0]  lane_valid;
    logic [3:0]  lane_ready = '0;
    logic        lane_is_copy;
    logic [6:0]  lane_len;
    logic [63:0] lane_data;
    logic [1:0]  lane_seq;
    logic        busy;
    logic        done;
    logic        err;
`ifdef PARSER_SCHED_STAT_EN
    logic [31:0] stat_lit_cnt;
    logic [31:0] stat_copy_cnt;
    logic [31:0] stat_stall_cnt;
`endif

    always #5 clk = ~clk;

    parser_token_scheduler #(
        .NUM_LANES (4),
        .TOK_W     (64),
        .SEQ_W     (2),
        .ULEN_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .ulen         (ulen),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_is_copy  (tok_is_copy),
        .tok_len      (tok_len),
        .tok_data     (tok_data),
        .lane_valid   (lane_valid),
        .lane_ready   (lane_ready),
        .lane_is_copy (lane_is_copy),
        .lane_len     (lane_len),
        .lane_data    (lane_data),
        .lane_seq     (lane_seq),
        .busy         (busy),
        .done         (done),
        .err          (err)
`ifdef PARSER_SCHED_STAT_EN
        ,
        .stat_lit_cnt   (stat_lit_cnt),
        .stat_copy_cnt  (stat_copy_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    typedef struct {
        logic [3:0]  lane;
        logic        cp;
        logic [6:0]  len;
        logic [63:0] data;
        logic [1:0]  seq;
    } exp_t;

    exp_t q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    int          m_ulen = 0;
    int          m_cnt  = 0;
    int          m_idx  = 0;
    int          n_disp = 0;
    int          stall_seen = 0;

    logic        prev_stall = 1'b0;
    logic [3:0]  prev_lv;
    logic [63:0] prev_data;
    logic [6:0]  prev_len;
    logic [1:0]  prev_seq;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: retire dispatches against the scoreboard, then log accepts
    always @(negedge clk) begin
        if (rst_n) begin
            if (|lane_valid) begin
                if (prev_stall) begin
                    chk("stall_lv", 64'(lane_valid), 64'(prev_lv));
                    chk("stall_data", lane_data, prev_data);
                    chk("stall_len", 64'(lane_len), 64'(prev_len));
                    chk("stall_seq", 64'(lane_seq), 64'(prev_seq));
                end
                if (|(lane_valid & lane_ready)) begin
                    n_disp++;
                    if (q.size() == 0) begin
                        chk("unexpected_dispatch", 64'(lane_valid), 64'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("disp_lane", 64'(lane_valid), 64'(e.lane));
                        chk("disp_copy", 64'(lane_is_copy), 64'(e.cp));
                        chk("disp_len", 64'(lane_len), 64'(e.len));
                        chk("disp_data", lane_data, e.data);
                        chk("disp_seq", 64'(lane_seq), 64'(e.seq));
                    end
                end else begin
                    stall_seen++;
                end
            end
            prev_stall = (|lane_valid) && !(|(lane_valid & lane_ready));
            prev_lv    = lane_valid;
            prev_data  = lane_data;
            prev_len   = lane_len;
            prev_seq   = lane_seq;
            if (tok_valid && tok_ready) begin
                if (tok_len == 0 || tok_len > 64 || m_cnt + int'(tok_len) > m_ulen) begin
                    m_cnt = m_ulen + 1;
                end else begin
                    exp_t e;
                    e.lane = 4'b0001 << (m_idx % 4);
                    e.cp   = tok_is_copy;
                    e.len  = tok_len;
                    e.data = tok_data;
                    e.seq  = 2'(m_idx % 4);
                    q.push_back(e);
                    m_idx++;
                    m_cnt += int'(tok_len);
                end
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_start(input int u);
        m_ulen = u;
        m_cnt  = 0;
        m_idx  = 0;
        ulen   = 32'(u);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic send(input logic cp, input logic [6:0] len, input logic [63:0] d);
        bit ok = 0;
        tok_valid   = 1'b1;
        tok_is_copy = cp;
        tok_len     = len;
        tok_data    = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tok_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done", 64'(done), 64'd1);
        chk("err_clear", 64'(err), 64'd0);
        chk("q_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        logic any_ready;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tok_ready", 64'(tok_ready), 64'd0);
        chk("rst_lane_valid", 64'(lane_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // two literals filling ulen exactly
        lane_ready = 4'b1111;
        do_start(10);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_ready", 64'(tok_ready), 64'd1);
        send(1'b0, 7'd4, 64'hA0);
        send(1'b0, 7'd6, 64'hA1);
        wait_done();
        chk("t1_ndisp", 64'(n_disp), 64'd2);
        chk("t1_ready_done", 64'(tok_ready), 64'd0);

        // lane 1 stalls five cycles; strict order must hold
        lane_ready = 4'b1101;
        n_disp     = 0;
        stall_seen = 0;
        do_start(6);
        fork
            begin
                repeat (7) @(posedge clk);
                #1;
                lane_ready = 4'b1111;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    send(1'b1, 7'd1, 64'hC00 + 64'(i));
                end
            end
        join
        wait_done();
        chk("t2_ndisp", 64'(n_disp), 64'd6);
        chk("t2_stalls", 64'(stall_seen), 64'd5);
`ifdef PARSER_SCHED_STAT_EN
        chk("t2_stat_copy", 64'(stat_copy_cnt), 64'd6);
        chk("t2_stat_lit", 64'(stat_lit_cnt), 64'd0);
        chk("t2_stat_stall", 64'(stat_stall_cnt), 64'd5);
`endif

        // overrun: second token exceeds ulen
        n_disp = 0;
        do_start(8);
        send(1'b0, 7'd5, 64'hB0);
        send(1'b0, 7'd4, 64'hB1);
        chk("t3_err", 64'(err), 64'd1);
        chk("t3_ready", 64'(tok_ready), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t3_first_disp", 64'(n_disp), 64'd1);
        chk("t3_q_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
        do_start(3);
        chk("t3_err_cleared", 64'(err), 64'd0);
        chk("t3_busy_again", 64'(busy), 64'd1);
        send(1'b1, 7'd3, 64'hB2);
        wait_done();

        // empty block and an illegal zero-length token
        do_start(0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        any_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            any_ready = any_ready | tok_ready;
        end
        chk("t4_never_ready", 64'(any_ready), 64'd0);
        @(posedge clk);
        #1;
        do_start(20);
        send(1'b0, 7'd0, 64'hD0);
        chk("t4_len0_err", 64'(err), 64'd1);

        // sequence tag wraps with a 2-bit tag
        n_disp = 0;
        do_start(6);
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 7'd1, 64'hE00 + 64'(i));
        end
        wait_done();
        chk("t5_ndisp", 64'(n_disp), 64'd6);

        // asynchronous reset while the hold is full
        lane_ready = 4'b0000;
        do_start(100);
        send(1'b1, 7'd64, 64'hF0);
        chk("t6_lv_before", 64'(lane_valid), 64'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_lv_async", 64'(lane_valid), 64'd0);
        chk("t6_ready_async", 64'(tok_ready), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        q.delete();
`ifdef PARSER_SCHED_STAT_EN
        chk("t6_stat_lit", 64'(stat_lit_cnt), 64'd0);
        chk("t6_stat_copy", 64'(stat_copy_cnt), 64'd0);
        chk("t6_stat_stall", 64'(stat_stall_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_idle_done", 64'(done), 64'd0);
        chk("t6_idle_err", 64'(err), 64'd0);
        chk("t6_idle_lv", 64'(lane_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
